instruction_rom_arbiter: RTL and testbench

Shares the single combinational read port of the instruction ROM between N_REQ requesters (CPU fetch, debug/trace reader, preloader check) using valid/ready request handshakes. Each granted read goes to the ROM and returns through a one-entry registered response buffer tagged with the requester id. The block sits between the ROM and its clients; it is the only driver of the ROM address.

---
 rtl/rom_arb_pkg.sv | 9 +
 rtl/rr_arbiter.sv | 50 +++++
 rtl/instruction_rom_arbiter.sv | 86 ++++++++
 tb/tb_instruction_rom_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/rom_arb_pkg.sv
// Shared constants for the instruction ROM arbiter.
// Holds the word width, the NOP used for out-of-range reads and the maximum requester count.
package rom_arb_pkg;

  localparam int ROM_WORD_W = 32;
  localparam logic [ROM_WORD_W-1:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0
  localparam int MAX_REQ = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Request arbiter: one-hot grant plus binary index of the winner.
// ROM_ARB_ROUND_ROBIN_EN selects round-robin (search from ptr+1); otherwise lowest index wins.
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

`ifdef ROM_ARB_ROUND_ROBIN_EN
  int cand;

  // Walk ptr+1 .. ptr+N so the previous winner is considered last.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = 0;
    for (int k = 1; k <= N; k++) begin
      cand = (int'(ptr) + k) % N;
      if (!any && req[cand]) begin
        gnt[cand] = 1'b1;
        idx       = IDX_W'(cand);
        any       = 1'b1;
      end
    end
  end
`else
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int p = 0; p < N; p++) begin
      if (!any && req[p]) begin
        gnt[p] = 1'b1;
        idx    = IDX_W'(p);
        any    = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/instruction_rom_arbiter.sv
// Shares the combinational instruction-ROM read port between N_REQ requesters via a one-entry response buffer.
// Build option: ROM_ARB_ROUND_ROBIN_EN enables round-robin arbitration (default fixed priority).
module instruction_rom_arbiter
  import rom_arb_pkg::*;
#(
  parameter int SIZE   = 64,
  parameter int ADDR_W = $clog2(SIZE),
  parameter int N_REQ  = 2,
  parameter int ID_W   = $clog2(N_REQ)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             req_valid,
  input  logic [N_REQ-1:0][ADDR_W-1:0] req_addr,
  output logic [N_REQ-1:0]             req_ready,
  output logic                         rsp_valid,
  output logic [ID_W-1:0]              rsp_id,
  output logic [ROM_WORD_W-1:0]        rsp_data,
  input  logic                         rsp_ready,
  output logic [ADDR_W-1:0]            rom_a,
  input  logic [ROM_WORD_W-1:0]        rom_rd
);

  // Handshake: a request transfers at the clock edge where req_valid[i] & req_ready[i];
  // a response transfers where rsp_valid & rsp_ready. Ready never waits on the same-port valid
  // beyond the combinational arbitration, and the buffer may refill in the cycle it drains.

  logic              grant_ok;
  logic [N_REQ-1:0]  arb_req;
  logic [N_REQ-1:0]  gnt;
  logic [ID_W-1:0]   win;
  logic              any_gnt;
  logic [ID_W-1:0]   last_grant;
  logic              in_range;
  logic [ROM_WORD_W-1:0] rd_word;

  assign grant_ok = !rsp_valid || rsp_ready;
  assign arb_req  = (rst || !grant_ok) ? '0 : req_valid;

  rr_arbiter #(
    .N     (N_REQ),
    .IDX_W (ID_W)
  ) u_arb (
    .req (arb_req),
    .ptr (last_grant),
    .gnt (gnt),
    .idx (win),
    .any (any_gnt)
  );

  assign req_ready = gnt;
  assign rom_a     = any_gnt ? req_addr[win] : '0;

  // Only a non-power-of-two depth leaves addresses past the end of the ROM.
  if (SIZE == (1 << ADDR_W)) begin : g_full_range
    assign in_range = 1'b1;
  end else begin : g_partial_range
    assign in_range = ({1'b0, rom_a} < (ADDR_W + 1)'(SIZE));
  end

  always_comb begin
    rd_word = rom_rd;
    if (!in_range) rd_word = NOP_INSTR;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_data   <= '0;
      last_grant <= ID_W'(N_REQ - 1);
    end else if (any_gnt) begin
      rsp_valid  <= 1'b1;
      rsp_id     <= win;
      rsp_data   <= rd_word;
      last_grant <= win;
    end else if (rsp_ready) begin
      rsp_valid  <= 1'b0;
    end
  end

  a_grant_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready));
  a_rsp_hold: assert property (@(posedge clk) disable iff (rst)
    (rsp_valid && !rsp_ready) |=> $stable({rsp_valid, rsp_id, rsp_data}));

endmodule

// File: tb/tb_instruction_rom_arbiter.sv
// Bench for instruction_rom_arbiter: directed scenarios then randomized traffic against a reference model.
// Expected arbitration follows ROM_ARB_ROUND_ROBIN_EN the same way the design build does.
module tb_instruction_rom_arbiter;

  localparam int SIZE   = 48;
  localparam int ADDR_W = 6;
  localparam int N_REQ  = 2;
  localparam int ID_W   = 1;
  localparam int SB_W   = ID_W + 32;

  // ---------------- clock / reset / dut ----------------
  logic                         clk = 1'b0;
  logic                         rst;
  logic [N_REQ-1:0]             req_valid;
  logic [N_REQ-1:0][ADDR_W-1:0] req_addr;
  logic [N_REQ-1:0]             req_ready;
  logic                         rsp_valid;
  logic [ID_W-1:0]              rsp_id;
  logic [31:0]                  rsp_data;
  logic                         rsp_ready;
  logic [ADDR_W-1:0]            rom_a;
  logic [31:0]                  rom_rd;
  logic [31:0]                  rom_mem [64];

  always #5 clk = ~clk;

  assign rom_rd = rom_mem[rom_a];

  instruction_rom_arbiter #(
    .SIZE   (SIZE),
    .ADDR_W (ADDR_W),
    .N_REQ  (N_REQ),
    .ID_W   (ID_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_ready (rsp_ready),
    .rom_a     (rom_a),
    .rom_rd    (rom_rd)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  bit               m_valid = 1'b0;
  int               m_id    = 0;
  logic [31:0]      m_data  = '0;
  int               m_last  = N_REQ - 1;
  logic [SB_W-1:0]  exp_q[$];
  logic [N_REQ-1:0] seen_ready;
  logic [N_REQ-1:0] last_exp_rdy = '0;

  // Winner among the valid requesters given the previous winner.
  function automatic int pick(input logic [N_REQ-1:0] v, input int last);
`ifdef ROM_ARB_ROUND_ROBIN_EN
    for (int k = 1; k <= N_REQ; k++) begin
      if (v[(last + k) % N_REQ]) return (last + k) % N_REQ;
    end
`else
    for (int p = 0; p < N_REQ; p++) begin
      if (v[p]) return p;
    end
`endif
    return -1;
  endfunction

  function automatic logic [31:0] rom_word(input logic [ADDR_W-1:0] a);
    return (int'(a) >= SIZE) ? 32'h0000_0013 : rom_mem[a];
  endfunction

  // ---------------- driver: one clock cycle ----------------
  task automatic step(input logic r, input logic [N_REQ-1:0] v,
                      input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1,
                      input logic rr);
    int               w;
    logic [N_REQ-1:0] exp_rdy;
    logic [ADDR_W-1:0] exp_a;
    logic [SB_W-1:0]  exp_rsp;
    @(negedge clk);
    check_eq("rsp_valid", rsp_valid, m_valid);
    if (m_valid) begin
      check_eq("rsp_id", rsp_id, m_id);
      check_eq("rsp_data", rsp_data, m_data);
    end
    rst         = r;
    req_valid   = v;
    req_addr[0] = a0;
    req_addr[1] = a1;
    rsp_ready   = rr;
    #1;
    w = -1;
    if (!r && (!m_valid || rr) && v != '0) w = pick(v, m_last);
    exp_rdy = '0;
    exp_a   = '0;
    if (w >= 0) begin
      exp_rdy[w] = 1'b1;
      exp_a      = req_addr[w];
    end
    check_eq("req_ready", req_ready, exp_rdy);
    check_eq("rom_a", rom_a, exp_a);
    seen_ready   = req_ready;
    last_exp_rdy = exp_rdy;
    if (!r && rsp_valid && rr) begin
      check_eq("sb_size", exp_q.size(), 1);
      if (exp_q.size() > 0) begin
        exp_rsp = exp_q.pop_front();
        check_eq("sb_rsp", {rsp_id, rsp_data}, exp_rsp);
      end
    end
    @(posedge clk);
    if (r) begin
      m_valid = 1'b0;
      m_id    = 0;
      m_data  = '0;
      m_last  = N_REQ - 1;
      exp_q.delete();
    end else if (w >= 0) begin
      m_valid = 1'b1;
      m_id    = w;
      m_data  = rom_word(req_addr[w]);
      m_last  = w;
      exp_q.push_back({ID_W'(w), m_data});
    end else if (rr) begin
      m_valid = 1'b0;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [N_REQ-1:0] cont_exp [4];
    logic [N_REQ-1:0] nv;
    logic [N_REQ-1:0][ADDR_W-1:0] na;
    logic nr, nrr;

    for (int i = 0; i < 64; i++) rom_mem[i] = $urandom;
    rom_mem[5] = 32'h0050_0093;
    rst = 1'b1; req_valid = '0; req_addr = '0; rsp_ready = 1'b0;

    // reset: no grant even with both requesting
    step(1'b1, 2'b11, 6'd1, 6'd2, 1'b0);
    step(1'b1, 2'b11, 6'd1, 6'd2, 1'b0);
    check_eq("reset_ready", seen_ready, 2'b00);
    #1;
    check_eq("reset_rsp", {rsp_valid, rsp_id, rsp_data}, '0);

    // single request
    step(1'b0, 2'b01, 6'd5, 6'd0, 1'b1);
    check_eq("single_ready", seen_ready, 2'b01);
    #1;
    check_eq("single_rsp", {rsp_valid, rsp_id, rsp_data}, {1'b1, 1'b0, 32'h0050_0093});

    // backpressure
    step(1'b0, 2'b01, 6'd7, 6'd0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 2'b10, 6'd0, 6'd9, 1'b0);
      check_eq("bp_ready", seen_ready, 2'b00);
      #1;
      check_eq("bp_hold", {rsp_valid, rsp_id, rsp_data}, {1'b1, 1'b0, rom_mem[7]});
    end
    step(1'b0, 2'b10, 6'd0, 6'd9, 1'b1);
    check_eq("bp_release_ready", seen_ready, 2'b10);
    #1;
    check_eq("bp_release_rsp", {rsp_valid, rsp_id, rsp_data}, {1'b1, 1'b1, rom_mem[9]});

    // out-of-range and boundary addresses
    step(1'b0, 2'b01, 6'd50, 6'd0, 1'b1);
    #1;
    check_eq("oor_50", rsp_data, 32'h0000_0013);
    step(1'b0, 2'b01, 6'd47, 6'd0, 1'b1);
    #1;
    check_eq("last_word_47", rsp_data, rom_mem[47]);
    step(1'b0, 2'b10, 6'd0, 6'd48, 1'b1);
    #1;
    check_eq("oor_48", {rsp_id, rsp_data}, {1'b1, 32'h0000_0013});

    // reset with a response pending
    step(1'b0, 2'b01, 6'd3, 6'd0, 1'b1);
    #1;
    check_eq("pre_reset_valid", rsp_valid, 1'b1);
    step(1'b1, 2'b11, 6'd4, 6'd6, 1'b1);
    check_eq("mid_reset_ready", seen_ready, 2'b00);
    #1;
    check_eq("post_reset_rsp", {rsp_valid, rsp_data}, '0);

    // contention with both held valid
`ifdef ROM_ARB_ROUND_ROBIN_EN
    cont_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    cont_exp = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 2'b11, 6'd4, 6'd6, 1'b1);
      check_eq($sformatf("contend_%0d", k), seen_ready, cont_exp[k]);
    end

    // random traffic; requesters hold valid/address until accepted
    for (int c = 0; c < 10000; c++) begin
      for (int p = 0; p < N_REQ; p++) begin
        if (req_valid[p] && !last_exp_rdy[p]) begin
          nv[p] = 1'b1;
          na[p] = req_addr[p];
        end else begin
          nv[p] = ($urandom_range(0, 99) < 60);
          na[p] = ADDR_W'($urandom_range(0, 63));
        end
      end
      nrr = ($urandom_range(0, 3) != 0);
      nr  = ($urandom_range(0, 999) == 0);
      step(nr, nv, na[0], na[1], nrr);
    end

    step(1'b0, 2'b00, 6'd0, 6'd0, 1'b1);
    step(1'b0, 2'b00, 6'd0, 6'd0, 1'b1);
    check_eq("sb_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
